// File: rtl/transformation_engine_if.sv
// Memory-side bus of the transformation engine: synchronous FM and WM read ports
// plus the FM_WM product-memory write port.
interface transformation_engine_if #(
    parameter int FEATURE_ROWS       = 6,
    parameter int FEATURE_COLS       = 96,
    parameter int FM_WM_COLS         = 3,
    parameter int DATA_WIDTH         = 8,
    parameter int ACC_WIDTH          = 16,
    parameter int FEATURE_ADDR_WIDTH = $clog2(FEATURE_ROWS * FEATURE_COLS),
    parameter int WEIGHT_ADDR_WIDTH  = $clog2(FEATURE_COLS * FM_WM_COLS)
);
    localparam int ROW_WIDTH = $clog2(FEATURE_ROWS);
    localparam int COL_WIDTH = $clog2(FM_WM_COLS);

    logic [FEATURE_ADDR_WIDTH-1:0] read_feature_addr;
    logic [DATA_WIDTH-1:0]         read_feature_data;
    logic [WEIGHT_ADDR_WIDTH-1:0]  read_weight_addr;
    logic [DATA_WIDTH-1:0]         read_weight_data;
    logic                          write_fm_wm_en;
    logic [ROW_WIDTH-1:0]          write_fm_wm_row;
    logic [COL_WIDTH-1:0]          write_fm_wm_col;
    logic [ACC_WIDTH-1:0]          write_fm_wm_data;

    modport master (
        output read_feature_addr,
        input  read_feature_data,
        output read_weight_addr,
        input  read_weight_data,
        output write_fm_wm_en,
        output write_fm_wm_row,
        output write_fm_wm_col,
        output write_fm_wm_data
    );

    modport slave (
        input  read_feature_addr,
        output read_feature_data,
        input  read_weight_addr,
        output read_weight_data,
        input  write_fm_wm_en,
        input  write_fm_wm_row,
        input  write_fm_wm_col,
        input  write_fm_wm_data
    );
endinterface

// File: rtl/transformation_engine.sv
// GCN transformation stage: computes FM x WM one dot product at a time with a
// sequential MAC and writes each result row-major into the FM_WM product memory.
module transformation_engine #(
    parameter int FEATURE_ROWS       = 6,
    parameter int FEATURE_COLS       = 96,
    parameter int FM_WM_COLS         = 3,
    parameter int DATA_WIDTH         = 8,
    parameter int ACC_WIDTH          = 16,
    parameter int FEATURE_ADDR_WIDTH = $clog2(FEATURE_ROWS * FEATURE_COLS),
    parameter int WEIGHT_ADDR_WIDTH  = $clog2(FEATURE_COLS * FM_WM_COLS)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    transformation_engine_if.master mem
);
    localparam int ROW_WIDTH  = $clog2(FEATURE_ROWS);
    localparam int COL_WIDTH  = $clog2(FM_WM_COLS);
    localparam int K_WIDTH    = $clog2(FEATURE_COLS);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [K_WIDTH-1:0]     k_q, k_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   valid_q, valid_d;

    logic signed [PROD_WIDTH-1:0] product;
    logic                         last_k;
    logic                         last_col;
    logic                         last_row;

    // Operands are widened first so the multiply yields the full signed product.
    assign product  = PROD_WIDTH'($signed(mem.read_feature_data))
                    * PROD_WIDTH'($signed(mem.read_weight_data));
    assign last_k   = (k_q == K_WIDTH'(FEATURE_COLS - 1));
    assign last_col = (col_q == COL_WIDTH'(FM_WM_COLS - 1));
    assign last_row = (row_q == ROW_WIDTH'(FEATURE_ROWS - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        acc_d   = acc_q;
        valid_d = (state_q == S_FETCH);

        busy                 = 1'b0;
        done                 = 1'b0;
        mem.read_feature_addr = '0;
        mem.read_weight_addr  = '0;
        mem.write_fm_wm_en    = 1'b0;
        mem.write_fm_wm_row   = '0;
        mem.write_fm_wm_col   = '0;
        mem.write_fm_wm_data  = '0;

        // Data arriving this cycle belongs to the address issued in the previous FETCH.
        if (valid_q) begin
            acc_d = acc_q + ACC_WIDTH'(product);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    valid_d = 1'b0;
                end
            end

            S_FETCH: begin
                busy = 1'b1;
                mem.read_feature_addr = FEATURE_ADDR_WIDTH'(row_q) * FEATURE_ADDR_WIDTH'(FEATURE_COLS)
                                      + FEATURE_ADDR_WIDTH'(k_q);
                mem.read_weight_addr  = WEIGHT_ADDR_WIDTH'(k_q) * WEIGHT_ADDR_WIDTH'(FM_WM_COLS)
                                      + WEIGHT_ADDR_WIDTH'(col_q);
                if (last_k) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + K_WIDTH'(1);
                end
            end

            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                busy                 = 1'b1;
                mem.write_fm_wm_en   = 1'b1;
                mem.write_fm_wm_row  = row_q;
                mem.write_fm_wm_col  = col_q;
                mem.write_fm_wm_data = acc_q;
                acc_d = '0;
                k_d   = '0;
                if (last_col) begin
                    col_d = '0;
                    row_d = last_row ? '0 : row_q + ROW_WIDTH'(1);
                end else begin
                    col_d = col_q + COL_WIDTH'(1);
                end
                state_d = (last_row && last_col) ? S_DONE : S_FETCH;
            end

            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_transformation_engine.sv
// Bench: a 2x3x2 engine driven from a vector table and corner sequences, plus a
// default-size engine checked against a golden dot-product model.
`timescale 1ns/1ps
module tb_transformation_engine;
    localparam int DW     = 8;
    localparam int AW     = 16;
    localparam int S_ROWS = 2;
    localparam int S_K    = 3;
    localparam int S_COLS = 2;
    localparam int S_P    = S_K + 2;
    localparam int S_N    = S_ROWS * S_COLS * S_P;
    localparam int L_ROWS = 6;
    localparam int L_K    = 96;
    localparam int L_COLS = 3;
    localparam int L_P    = L_K + 2;
    localparam int L_N    = L_ROWS * L_COLS * L_P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_s   = 1'b0;
    logic rst_l   = 1'b0;
    logic start_s = 1'b0;
    logic start_l = 1'b0;
    logic busy_s, done_s, busy_l, done_l;

    transformation_engine_if #(.FEATURE_ROWS(S_ROWS), .FEATURE_COLS(S_K), .FM_WM_COLS(S_COLS),
                               .DATA_WIDTH(DW), .ACC_WIDTH(AW)) s_if ();
    transformation_engine_if #(.FEATURE_ROWS(L_ROWS), .FEATURE_COLS(L_K), .FM_WM_COLS(L_COLS),
                               .DATA_WIDTH(DW), .ACC_WIDTH(AW)) l_if ();

    transformation_engine #(.FEATURE_ROWS(S_ROWS), .FEATURE_COLS(S_K), .FM_WM_COLS(S_COLS),
                            .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut_s (
        .clk   (clk),
        .reset (rst_s),
        .start (start_s),
        .busy  (busy_s),
        .done  (done_s),
        .mem   (s_if.master)
    );

    transformation_engine #(.FEATURE_ROWS(L_ROWS), .FEATURE_COLS(L_K), .FM_WM_COLS(L_COLS),
                            .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut_l (
        .clk   (clk),
        .reset (rst_l),
        .start (start_l),
        .busy  (busy_l),
        .done  (done_l),
        .mem   (l_if.master)
    );

    // Synchronous-read memories, one-cycle latency, always enabled
    logic signed [DW-1:0] s_fm [S_ROWS*S_K];
    logic signed [DW-1:0] s_wm [S_K*S_COLS];
    logic signed [DW-1:0] l_fm [L_ROWS*L_K];
    logic signed [DW-1:0] l_wm [L_K*L_COLS];

    always @(posedge clk) begin
        s_if.read_feature_data <= s_fm[s_if.read_feature_addr];
        s_if.read_weight_data  <= s_wm[s_if.read_weight_addr];
        l_if.read_feature_data <= l_fm[l_if.read_feature_addr];
        l_if.read_weight_data  <= l_wm[l_if.read_weight_addr];
    end

    typedef struct {
        int          row;
        int          col;
        logic [AW-1:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic signed [DW-1:0] feat;
        logic signed [DW-1:0] wt;
        logic [AW-1:0]        exp_data;
    } vec_t;

    exp_t s_q[$];
    exp_t l_q[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int s_t0   = 0;
    int l_t0   = 0;
    bit s_addr_chk = 1'b0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumers: every write strobe pops and checks one expectation
    always @(negedge clk) begin : mon_s
        exp_t e;
        if (s_if.write_fm_wm_en === 1'b1) begin
            $display("[%0d] s write row=%0d col=%0d data=%h", cyc - s_t0,
                     s_if.write_fm_wm_row, s_if.write_fm_wm_col, s_if.write_fm_wm_data);
            if (s_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_write: actual row=%0d col=%0d data=%h required no write",
                         s_if.write_fm_wm_row, s_if.write_fm_wm_col, s_if.write_fm_wm_data);
            end else begin
                e = s_q.pop_front();
                check_int("s_write_row", int'(s_if.write_fm_wm_row), e.row);
                check_int("s_write_col", int'(s_if.write_fm_wm_col), e.col);
                check_int("s_write_data", int'(s_if.write_fm_wm_data), int'(e.data));
                check_int("s_write_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_l
        exp_t e;
        if (l_if.write_fm_wm_en === 1'b1) begin
            $display("[%0d] l write row=%0d col=%0d data=%h", cyc - l_t0,
                     l_if.write_fm_wm_row, l_if.write_fm_wm_col, l_if.write_fm_wm_data);
            if (l_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL l_unexpected_write: actual row=%0d col=%0d data=%h required no write",
                         l_if.write_fm_wm_row, l_if.write_fm_wm_col, l_if.write_fm_wm_data);
            end else begin
                e = l_q.pop_front();
                check_int("l_write_row", int'(l_if.write_fm_wm_row), e.row);
                check_int("l_write_col", int'(l_if.write_fm_wm_col), e.col);
                check_int("l_write_data", int'(l_if.write_fm_wm_data), int'(e.data));
                check_int("l_write_cycle", cyc, e.cyc);
            end
        end
    end

    // Expected read addresses derived from the cycle position within each element
    always @(negedge clk) begin : addr_chk
        int c, e, p, efa, ewa;
        if (s_addr_chk && rst_s) begin
            c = cyc - s_t0;
            efa = 0;
            ewa = 0;
            if (c >= 1 && c <= S_N) begin
                e = (c - 1) / S_P;
                p = (c - 1) % S_P;
                if (p < S_K) begin
                    efa = (e / S_COLS) * S_K + p;
                    ewa = p * S_COLS + (e % S_COLS);
                end
            end
            check_int("s_feature_addr", int'(s_if.read_feature_addr), efa);
            check_int("s_weight_addr", int'(s_if.read_weight_addr), ewa);
        end
    end

    task automatic s_check_zero(input string tag);
        check_int({tag, "_faddr"}, int'(s_if.read_feature_addr), 0);
        check_int({tag, "_waddr"}, int'(s_if.read_weight_addr), 0);
        check_int({tag, "_wen"},   int'(s_if.write_fm_wm_en), 0);
        check_int({tag, "_wrow"},  int'(s_if.write_fm_wm_row), 0);
        check_int({tag, "_wcol"},  int'(s_if.write_fm_wm_col), 0);
        check_int({tag, "_wdata"}, int'(s_if.write_fm_wm_data), 0);
        check_int({tag, "_busy"},  int'(busy_s), 0);
        check_int({tag, "_done"},  int'(done_s), 0);
    endtask

    task automatic l_check_zero(input string tag);
        check_int({tag, "_faddr"}, int'(l_if.read_feature_addr), 0);
        check_int({tag, "_waddr"}, int'(l_if.read_weight_addr), 0);
        check_int({tag, "_wen"},   int'(l_if.write_fm_wm_en), 0);
        check_int({tag, "_wdata"}, int'(l_if.write_fm_wm_data), 0);
        check_int({tag, "_busy"},  int'(busy_l), 0);
        check_int({tag, "_done"},  int'(done_l), 0);
    endtask

    task automatic s_fill(input logic signed [DW-1:0] f, input logic signed [DW-1:0] w);
        for (int i = 0; i < S_ROWS * S_K; i++) s_fm[i] = f;
        for (int i = 0; i < S_K * S_COLS; i++) s_wm[i] = w;
    endtask

    // Cycle numbering: the period right after the start-sampling edge is cycle 1
    task automatic s_start(input bit hold);
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        s_t0 = cyc - 1;
        if (!hold) start_s = 1'b0;
    endtask

    task automatic l_start();
        @(negedge clk);
        start_l = 1'b1;
        @(posedge clk);
        #1;
        l_t0 = cyc - 1;
        start_l = 1'b0;
    endtask

    task automatic s_push_const(input int t0, input logic [AW-1:0] d);
        for (int e = 0; e < S_ROWS * S_COLS; e++) begin
            exp_t x;
            x.row  = e / S_COLS;
            x.col  = e % S_COLS;
            x.data = d;
            x.cyc  = t0 + (e + 1) * S_P;
            s_q.push_back(x);
        end
    endtask

    task automatic s_push_golden(input int t0);
        for (int e = 0; e < S_ROWS * S_COLS; e++) begin
            exp_t x;
            int   sum;
            sum = 0;
            x.row = e / S_COLS;
            x.col = e % S_COLS;
            for (int k = 0; k < S_K; k++)
                sum += int'(s_fm[x.row * S_K + k]) * int'(s_wm[k * S_COLS + x.col]);
            x.data = AW'(sum);
            x.cyc  = t0 + (e + 1) * S_P;
            s_q.push_back(x);
        end
    endtask

    task automatic l_push_golden(input int t0);
        for (int e = 0; e < L_ROWS * L_COLS; e++) begin
            exp_t x;
            int   sum;
            sum = 0;
            x.row = e / L_COLS;
            x.col = e % L_COLS;
            for (int k = 0; k < L_K; k++)
                sum += int'(l_fm[x.row * L_K + k]) * int'(l_wm[k * L_COLS + x.col]);
            x.data = AW'(sum);
            x.cyc  = t0 + (e + 1) * L_P;
            l_q.push_back(x);
        end
    endtask

    task automatic s_wait_done(input string tag);
        int   n;
        logic last_busy;
        n = 0;
        last_busy = busy_s;
        while (done_s !== 1'b1 && n < 10 * S_N) begin
            last_busy = busy_s;
            @(negedge clk);
            n++;
        end
        if (done_s !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: actual done=%b after %0d cycles required 1", tag, done_s, n);
        end else begin
            check_int({tag, "_done_cycle"}, cyc - s_t0, S_N + 1);
            check_int({tag, "_busy_before_done"}, int'(last_busy), 1);
            check_int({tag, "_busy_at_done"}, int'(busy_s), 0);
            check_int({tag, "_pending_writes"}, s_q.size(), 0);
        end
    endtask

    task automatic l_wait_done(input string tag);
        int n;
        n = 0;
        while (done_l !== 1'b1 && n < 2 * L_N) begin
            @(negedge clk);
            n++;
        end
        if (done_l !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: actual done=%b after %0d cycles required 1", tag, done_l, n);
        end else begin
            check_int({tag, "_done_cycle"}, cyc - l_t0, L_N + 1);
            check_int({tag, "_busy_at_done"}, int'(busy_l), 0);
            check_int({tag, "_pending_writes"}, l_q.size(), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{feat:  8'sd1,   wt:  8'sd1,   exp_data: 16'h0003};
        vecs[1] = '{feat: -8'sd2,   wt:  8'sd3,   exp_data: 16'hFFEE};
        vecs[2] = '{feat:  8'sd127, wt:  8'sd127, exp_data: 16'hBD03};
        vecs[3] = '{feat: -8'sd128, wt: -8'sd128, exp_data: 16'hC000};
        vecs[4] = '{feat: -8'sd128, wt:  8'sd127, exp_data: 16'h4180};
        vecs[5] = '{feat:  8'sd0,   wt:  8'sd5,   exp_data: 16'h0000};
        s_fill(8'sd0, 8'sd0);
        for (int i = 0; i < L_ROWS * L_K; i++) l_fm[i] = 8'sd0;
        for (int i = 0; i < L_K * L_COLS; i++) l_wm[i] = 8'sd0;

        #1;
        s_check_zero("s_reset");
        l_check_zero("l_reset");
        repeat (3) @(negedge clk);
        rst_s = 1'b1;
        rst_l = 1'b1;
        @(negedge clk);
        s_check_zero("s_idle");

        // Uniform-data vectors: every element equals K*f*w modulo 2^16
        for (int i = 0; i < 6; i++) begin
            s_fill(vecs[i].feat, vecs[i].wt);
            s_start(1'b0);
            s_push_const(s_t0, vecs[i].exp_data);
            s_addr_chk = 1'b1;
            s_wait_done($sformatf("vec%0d", i));
            s_addr_chk = 1'b0;
        end

        // Per-element distinct data so row/col or address mix-ups show up
        for (int i = 0; i < S_ROWS * S_K; i++) s_fm[i] = DW'($urandom);
        for (int i = 0; i < S_K * S_COLS; i++) s_wm[i] = DW'($urandom);
        s_start(1'b0);
        s_push_golden(s_t0);
        s_addr_chk = 1'b1;
        s_wait_done("s_random");
        s_addr_chk = 1'b0;

        // start held high: ignored while busy, relaunches once DONE is reached
        s_fill(8'sd1, 8'sd1);
        s_start(1'b1);
        s_push_const(s_t0, 16'h0003);
        s_wait_done("hold1");
        s_t0 = cyc;
        s_push_const(s_t0, 16'h0003);
        @(posedge clk);
        #1;
        check_int("hold_done_cleared", int'(done_s), 0);
        check_int("hold_busy_restart", int'(busy_s), 1);
        repeat (6) @(negedge clk);
        start_s = 1'b0;
        s_wait_done("hold2");
        repeat (4) @(negedge clk);
        check_int("hold_done_sticky", int'(done_s), 1);
        check_int("hold_idle_after_done", int'(busy_s), 0);

        // Reset in the middle of the second element's fetch
        s_start(1'b0);
        s_push_const(s_t0, 16'h0003);
        while (cyc - s_t0 < 7) @(negedge clk);
        check_int("pre_reset_busy", int'(busy_s), 1);
        rst_s = 1'b0;
        #1;
        s_check_zero("midreset");
        check_int("midreset_writes_before", s_q.size(), 3);
        s_q.delete();
        repeat (5) @(negedge clk);
        s_check_zero("held_reset");
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        s_check_zero("post_reset_idle");
        s_start(1'b0);
        s_push_const(s_t0, 16'h0003);
        s_wait_done("after_reset");

        // Default-size engine against the golden model
        for (int i = 0; i < L_ROWS * L_K; i++) l_fm[i] = DW'($urandom);
        for (int i = 0; i < L_K * L_COLS; i++) l_wm[i] = DW'($urandom);
        l_start();
        l_push_golden(l_t0);
        l_wait_done("l_random");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/transformation_engine.md
# transformation_engine

Computes the GCN transformation product FM×WM (node feature matrix times weight matrix) one dot product at a time. Each dot product is a sequential multiply-accumulate over feature-memory and weight-memory reads. Results are written element by element into the FM_WM product memory. `done` hands off to the combination stage, which then walks the COO edge list over that product memory.

## Interface
- `FEATURE_ROWS`, default 6: number of graph nodes, i.e. rows of FM and of FM_WM.
- `FEATURE_COLS`, default 96: inner dimension K (FM columns = WM rows); must be ≥ 2.
- `FM_WM_COLS`, default 3: WM columns, i.e. columns of FM_WM.
- `DATA_WIDTH`, default 8: width of feature and weight elements; both are signed two's complement.
- `ACC_WIDTH`, default 16: accumulator and write-data width.
- `FEATURE_ADDR_WIDTH`, default $clog2(FEATURE_ROWS*FEATURE_COLS): feature read-address width.
- `WEIGHT_ADDR_WIDTH`, default $clog2(FEATURE_COLS*FM_WM_COLS): weight read-address width.

Ports:
- `clk`  in  1  single clock; all flops use its rising edge.
- `reset`  in  1  asynchronous, active-low; asserted at 0, released at 1.
- `start`  in  1  level-sampled request to begin a full matrix product.
- `read_feature_addr`  out  FEATURE_ADDR_WIDTH  equals row*FEATURE_COLS + k.
- `read_feature_data`  in  DATA_WIDTH  FM element; valid exactly 1 cycle after its address.
- `read_weight_addr`  out  WEIGHT_ADDR_WIDTH  equals k*FM_WM_COLS + col.
- `read_weight_data`  in  DATA_WIDTH  WM element; valid exactly 1 cycle after its address.
- `write_fm_wm_en`  out  1  one-cycle write strobe into the product memory.
- `write_fm_wm_row`  out  $clog2(FEATURE_ROWS)  destination row.
- `write_fm_wm_col`  out  $clog2(FM_WM_COLS)  destination column.
- `write_fm_wm_data`  out  ACC_WIDTH  finished dot product.
- `busy`  out  1  high from the first FETCH cycle through the last WRITE cycle.
- `done`  out  1  sticky completion flag; drives the combination stage's `start`.

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
  - IDLE → FETCH when `start`=1. Clears row, col, k, the accumulator and the data-valid pipeline flag.
  - FETCH drives both read addresses from (row, col, k) and increments k. When k = FEATURE_COLS-1, next state is DRAIN.
  - DRAIN: no address is issued; the last returning product is accumulated; next state is WRITE.
  - WRITE: `write_fm_wm_en`=1 with current row/col and `write_fm_wm_data`=acc. acc and k are cleared. col advances; on col wrap (FM_WM_COLS-1 → 0), row advances.
  - After WRITE: if row = FEATURE_ROWS-1 and col = FM_WM_COLS-1, next state is DONE; otherwise FETCH.
  - DONE: `done`=1. With `start`=1, go to FETCH and restart a fresh product, clearing row, col, k, acc and `done`. Otherwise hold.
- Data-valid flag: registered one-cycle copy of "state==FETCH". When set, acc ← acc + sext(read_feature_data × read_weight_data).
- Arithmetic: full 2·DATA_WIDTH signed product, sign-extended to ACC_WIDTH. Addition wraps modulo 2^ACC_WIDTH with no saturation.
- `start` is ignored in FETCH, DRAIN and WRITE.
- Outside FETCH, both read addresses are 0. Outside WRITE, `write_fm_wm_en`, row, col and data are 0.
- Write order is row-major: (0,0), (0,1), …, (0,FM_WM_COLS-1), (1,0), …

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE. Every output is 0: both addresses, the write strobe/row/col/data, `busy` and `done`. Counters, acc and the valid flag are cleared.
- Reset mid-operation aborts immediately. No write is issued after reset asserts; the product memory contents are left as they are.
- Cycle count per output element is FEATURE_COLS + 2 (FEATURE_COLS FETCH, 1 DRAIN, 1 WRITE).
- Let cycle 0 be the edge that samples `start` in IDLE. First FETCH is cycle 1.
- First write strobe is at cycle FEATURE_COLS+2.
- Last write strobe is at cycle N = FEATURE_ROWS·FM_WM_COLS·(FEATURE_COLS+2).
- `done` rises at cycle N+1; `busy` falls at the same edge.
- Memory contract: synchronous read, 1-cycle latency, read port always enabled.

## Test plan
1. Parameters 2/3/2 (rows/K/cols); all features=1, all weights=1; `start` pulsed → four writes of 3 at (0,0), (0,1), (1,0), (1,1), on cycles 5, 10, 15, 20; `done`=1 at cycle 21.
2. Same params; features=-2, weights=3 → every write_data = -18 (0xFFEE); check the address sequence, e.g. row 1 col 1 issues feature addrs 3,4,5 and weight addrs 1,3,5.
3. Overflow wrap: K=3; features=127, weights=127 → write_data = 48387 mod 2^16 = 0xBD03 (signed -17149); no saturation.
4. `start` held high through the run → no restart while busy; after `done`, a further `start`=1 clears `done` next cycle and reproduces scenario 1's write sequence.
5. `reset`=0 asserted at cycle 7 of scenario 1 → all outputs 0 immediately, no further writes. Release `reset` and pulse `start` → full correct four-write sequence.
6. Default parameters (6/96/3), random signed data against a software golden model → 18 writes, row-major order, all values match; `done` at cycle 1765.
